// File: rtl/mfm_encoder.sv
// MFM write encoder: single-byte holding register feeding a 16-cell shifter.
// Each byte becomes (clock, data) cell pairs, MSB first; each cell lasts
// CELL_CYCLES clocks, and a 1-cell drives mfm_out high for PULSE_CYCLES clocks.
module mfm_encoder #(
    parameter int CELL_CYCLES  = 5,
    parameter int PULSE_CYCLES = 2
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       mark_in,
    output logic       data_ready,
    output logic       mfm_out,
    output logic       write_gate,
    output logic       underrun
);

    localparam int CW = (CELL_CYCLES > 1) ? $clog2(CELL_CYCLES) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_hold_data;
    logic            r_hold_mark;
    logic            r_hold_full, w_hold_full_nxt;
    logic [15:0]     r_shift, w_shift_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]      r_idx, w_idx_nxt;
    logic            r_prev, w_prev_nxt;
    logic            r_ready, r_mfm, r_wg, r_underrun;
    logic            w_mfm_nxt, w_wg_nxt, w_underrun_nxt;
    logic            w_accept, w_cell_wrap, w_load, w_stop;

    // Expand a byte into clock/data cell pairs; pair for bit 7 sits in [15:14].
    function automatic logic [15:0] encode(input logic [7:0] d, input logic m, input logic p);
        logic [8:0]  ext;
        logic [15:0] cells;
        ext   = {p, d};
        cells = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cells[2*i]   = ext[i];
            cells[2*i+1] = ~ext[i+1] & ~ext[i] & ~(m && (i == 2));
        end
        return cells;
    endfunction

    assign w_accept    = data_valid & r_ready;
    assign w_cell_wrap = (r_cnt == CW'(CELL_CYCLES - 1));

    // State register plus datapath and registered outputs.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_hold_data <= '0;
            r_hold_mark <= 1'b0;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_prev      <= 1'b0;
            r_ready     <= 1'b1;
            r_mfm       <= 1'b0;
            r_wg        <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            if (w_accept) begin
                r_hold_data <= data_in;
                r_hold_mark <= mark_in;
            end
            r_hold_full <= w_hold_full_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_prev      <= w_prev_nxt;
            r_ready     <= ~w_hold_full_nxt;
            r_mfm       <= w_mfm_nxt;
            r_wg        <= w_wg_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

    // Next state: load whenever the holder is full at IDLE or at end of cell 15.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_hold_full) begin
                    w_state_nxt = ACTIVE;
                    w_load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_cell_wrap && (r_idx == 4'd15)) begin
                    if (r_hold_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_stop      = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath next values: shifter, cell counter/index, prev bit, holder flag.
    always_comb begin
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_prev_nxt      = r_prev;
        w_hold_full_nxt = r_hold_full;
        if (w_load) begin
            w_shift_nxt     = encode(r_hold_data, r_hold_mark, r_prev);
            w_cnt_nxt       = '0;
            w_idx_nxt       = '0;
            w_prev_nxt      = r_hold_data[0];
            w_hold_full_nxt = 1'b0;
        end else if (w_stop) begin
            w_cnt_nxt  = '0;
            w_idx_nxt  = '0;
            w_prev_nxt = 1'b0;
        end else if (r_state == ACTIVE) begin
            if (w_cell_wrap) begin
                w_cnt_nxt = '0;
                w_idx_nxt = r_idx + 4'd1;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
        // Accept never coincides with a load: data_ready is low while full.
        if (w_accept) begin
            w_hold_full_nxt = 1'b1;
        end
    end

    // Outputs computed from next-cycle values so the first cell shows right after load.
    always_comb begin
        w_wg_nxt       = (w_state_nxt == ACTIVE);
        w_mfm_nxt      = w_wg_nxt && w_shift_nxt[4'd15 - w_idx_nxt]
                         && (w_cnt_nxt < CW'(PULSE_CYCLES));
        w_underrun_nxt = w_stop;
    end

    assign data_ready = r_ready;
    assign mfm_out    = r_mfm;
    assign write_gate = r_wg;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_mfm_encoder.sv
// Directed bench for mfm_encoder at default parameters (5-cycle cell, 2-cycle pulse).
module tb_mfm_encoder;

    logic       clk_50 = 1'b0;
    logic       reset_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       mark_in;
    logic       data_ready;
    logic       mfm_out;
    logic       write_gate;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    mfm_encoder #(.CELL_CYCLES(5), .PULSE_CYCLES(2)) dut (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .mark_in    (mark_in),
        .data_ready (data_ready),
        .mfm_out    (mfm_out),
        .write_gate (write_gate),
        .underrun   (underrun)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a byte at a negedge; returns at the negedge after the load edge.
    task automatic send(input logic [7:0] d, input logic m, input logic keep, input logic [7:0] d2);
        data_in    = d;
        mark_in    = m;
        data_valid = 1'b1;
        @(negedge clk_50);
        chk("acc_ready", data_ready, 1'b0);
        chk("acc_wg", write_gate, 1'b0);
        chk("acc_mfm", mfm_out, 1'b0);
        if (keep) begin
            data_in = d2;
            mark_in = 1'b0;
        end else begin
            data_valid = 1'b0;
            data_in    = 8'h5A;
            mark_in    = 1'b1;
        end
        @(negedge clk_50);
    endtask

    // Check 80 samples of one byte against a hand-derived 16-cell pattern.
    task automatic check_byte(input string tag, input logic [15:0] exp, input logic rdy0,
                              input logic rdyn, input logic drop);
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 5; k++) begin
                chk({tag, "_mfm"}, mfm_out, exp[15-c] && (k < 2));
                chk({tag, "_wg"}, write_gate, 1'b1);
                chk({tag, "_rdy"}, data_ready, (c == 0 && k == 0) ? rdy0 : rdyn);
                chk({tag, "_und"}, underrun, 1'b0);
                if (c == 0 && k == 0 && drop) data_valid = 1'b0;
                @(negedge clk_50);
            end
        end
    endtask

    task automatic check_end(input string tag);
        chk({tag, "_end_wg"}, write_gate, 1'b0);
        chk({tag, "_end_und"}, underrun, 1'b1);
        chk({tag, "_end_mfm"}, mfm_out, 1'b0);
        chk({tag, "_end_rdy"}, data_ready, 1'b1);
        @(negedge clk_50);
        chk({tag, "_post_und"}, underrun, 1'b0);
        chk({tag, "_post_wg"}, write_gate, 1'b0);
        @(negedge clk_50);
    endtask

    initial begin
        reset_n    = 1'b0;
        data_valid = 1'b1;
        data_in    = 8'hFF;
        mark_in    = 1'b0;
        @(negedge clk_50);
        chk("rst_mfm", mfm_out, 1'b0);
        chk("rst_wg", write_gate, 1'b0);
        chk("rst_rdy", data_ready, 1'b1);
        chk("rst_und", underrun, 1'b0);
        reset_n    = 1'b1;
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_50);
            chk("rst_noacc_wg", write_gate, 1'b0);
            chk("rst_noacc_rdy", data_ready, 1'b1);
        end

        // Sync mark 0xA1 then the same byte without mark.
        send(8'hA1, 1'b1, 1'b0, 8'h00);
        check_byte("a1mark", 16'h4489, 1'b1, 1'b1, 1'b0);
        check_end("a1mark");
        send(8'hA1, 1'b0, 1'b0, 8'h00);
        check_byte("a1", 16'h44A9, 1'b1, 1'b1, 1'b0);
        check_end("a1");

        // 0x00 from IDLE after a byte ending in 1: prev must have cleared.
        send(8'h00, 1'b0, 1'b0, 8'h00);
        check_byte("zero", 16'hAAAA, 1'b1, 1'b1, 1'b0);
        check_end("zero");

        // Back-to-back with data_valid held high: exactly one byte per load.
        send(8'hFF, 1'b0, 1'b1, 8'h00);
        check_byte("ff", 16'h5555, 1'b1, 1'b0, 1'b0);
        check_byte("ff_00", 16'h2AAA, 1'b1, 1'b1, 1'b1);
        check_end("b2b");

        // Reset mid-byte with a second byte held.
        send(8'h00, 1'b0, 1'b1, 8'hFF);
        @(negedge clk_50);
        data_valid = 1'b0;
        chk("mid_held_rdy", data_ready, 1'b0);
        for (int i = 0; i < 38; i++) begin
            chk("mid_wg", write_gate, 1'b1);
            @(negedge clk_50);
        end
        reset_n = 1'b0;
        @(negedge clk_50);
        chk("midrst_mfm", mfm_out, 1'b0);
        chk("midrst_wg", write_gate, 1'b0);
        chk("midrst_rdy", data_ready, 1'b1);
        chk("midrst_und", underrun, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_50);
            chk("midrst_idle_wg", write_gate, 1'b0);
            chk("midrst_idle_mfm", mfm_out, 1'b0);
            chk("midrst_idle_und", underrun, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
